// File: rtl/sc_regbus_sequencer_if.sv
// Request and register-bus signals between the sequencer and the uDataPath register bank.
// master: the sequencer itself. slave: the requester and register bank side.
interface sc_regbus_sequencer_if #(
    parameter int unsigned DATAWIDTH_BUS = 32,
    parameter int unsigned NUM_REGS      = 8,
    parameter int unsigned SEL_WIDTH     = 3
);
    logic                     SC_RegBUSSEQ_ReqValid;
    logic                     SC_RegBUSSEQ_ReqReady;
    logic [SEL_WIDTH-1:0]     SC_RegBUSSEQ_SrcA;
    logic [SEL_WIDTH-1:0]     SC_RegBUSSEQ_SrcB;
    logic [SEL_WIDTH-1:0]     SC_RegBUSSEQ_Dst;
    logic [1:0]               SC_RegBUSSEQ_Op;
    logic [NUM_REGS-1:0]      SC_RegBUSSEQ_ENABLE_BUS_A;
    logic [NUM_REGS-1:0]      SC_RegBUSSEQ_ENABLE_BUS_B;
    logic [NUM_REGS-1:0]      SC_RegBUSSEQ_Write_InHigh;
    logic [DATAWIDTH_BUS-1:0] SC_RegBUSSEQ_DataBUS_A;
    logic [DATAWIDTH_BUS-1:0] SC_RegBUSSEQ_DataBUS_B;
    logic [DATAWIDTH_BUS-1:0] SC_RegBUSSEQ_DataBUS_Out;
    logic                     SC_RegBUSSEQ_Done;
    logic [DATAWIDTH_BUS-1:0] SC_RegBUSSEQ_Result;
    logic                     SC_RegBUSSEQ_Carry;
    logic                     SC_RegBUSSEQ_Zero;

    modport master (
        input  SC_RegBUSSEQ_ReqValid, SC_RegBUSSEQ_SrcA, SC_RegBUSSEQ_SrcB, SC_RegBUSSEQ_Dst,
               SC_RegBUSSEQ_Op, SC_RegBUSSEQ_DataBUS_A, SC_RegBUSSEQ_DataBUS_B,
        output SC_RegBUSSEQ_ReqReady, SC_RegBUSSEQ_ENABLE_BUS_A, SC_RegBUSSEQ_ENABLE_BUS_B,
               SC_RegBUSSEQ_Write_InHigh, SC_RegBUSSEQ_DataBUS_Out, SC_RegBUSSEQ_Done,
               SC_RegBUSSEQ_Result, SC_RegBUSSEQ_Carry, SC_RegBUSSEQ_Zero
    );

    modport slave (
        output SC_RegBUSSEQ_ReqValid, SC_RegBUSSEQ_SrcA, SC_RegBUSSEQ_SrcB, SC_RegBUSSEQ_Dst,
               SC_RegBUSSEQ_Op, SC_RegBUSSEQ_DataBUS_A, SC_RegBUSSEQ_DataBUS_B,
        input  SC_RegBUSSEQ_ReqReady, SC_RegBUSSEQ_ENABLE_BUS_A, SC_RegBUSSEQ_ENABLE_BUS_B,
               SC_RegBUSSEQ_Write_InHigh, SC_RegBUSSEQ_DataBUS_Out, SC_RegBUSSEQ_Done,
               SC_RegBUSSEQ_Result, SC_RegBUSSEQ_Carry, SC_RegBUSSEQ_Zero
    );
endinterface

// File: rtl/sc_regbus_sequencer.sv
// Register-bus sequencer: read two registers onto buses A/B, apply a 2-bit ALU op, write the
// result back with a one-hot strobe. One request every 5 cycles (IDLE READ EXEC WRITE DONE).
// Optional macro SC_REGBUSSEQ_STATUS_EN: when defined, Carry/Zero are registered in EXEC;
// otherwise both flags are tied to 0.
// SEL_WIDTH must satisfy 2**SEL_WIDTH >= NUM_REGS.
module sc_regbus_sequencer #(
    parameter int unsigned DATAWIDTH_BUS = 32,
    parameter int unsigned NUM_REGS      = 8,
    parameter int unsigned SEL_WIDTH     = 3
) (
    input logic                   SC_RegBUSSEQ_CLOCK_50,
    input logic                   SC_RegGENERAL_Reset_InHigh,
    sc_regbus_sequencer_if.master bus
);
    localparam int unsigned AluW = DATAWIDTH_BUS + 1;

    typedef enum logic [2:0] {StIdle, StRead, StExec, StWrite, StDone} state_e;

    state_e                   r_state, w_state_next;
    logic                     w_accept;
    logic [SEL_WIDTH-1:0]     r_src_a, r_src_b, r_dst;
    logic [1:0]               r_op;
    logic [DATAWIDTH_BUS-1:0] r_opnd_a, r_opnd_b;
    logic [NUM_REGS-1:0]      r_en_a, r_en_b, r_wr;
    logic [DATAWIDTH_BUS-1:0] r_dout, r_result;
    logic                     r_done;
    logic [AluW-1:0]          w_alu;
    logic                     w_src_a_ok, w_src_b_ok;

    // Out-of-range selects decode to an all-zero vector.
    function automatic logic [NUM_REGS-1:0] f_onehot(input logic [SEL_WIDTH-1:0] i_sel);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) v[i] = (int'(i_sel) == i);
        return v;
    endfunction

    assign w_src_a_ok = 32'(r_src_a) < NUM_REGS;
    assign w_src_b_ok = 32'(r_src_b) < NUM_REGS;

    // State register.
    always_ff @(posedge SC_RegBUSSEQ_CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
        if (SC_RegGENERAL_Reset_InHigh) r_state <= StIdle;
        else                            r_state <= w_state_next;
    end

    // Next-state: fixed one-cycle-per-state walk, leaving IDLE only on a valid request.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.SC_RegBUSSEQ_ReqValid) begin
                    w_state_next = StRead;
                    w_accept     = 1'b1;
                end
            end
            StRead:  w_state_next = StExec;
            StExec:  w_state_next = StWrite;
            StWrite: w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // ALU in DATAWIDTH_BUS+1 bits so the top bit is the carry (SUB: 1 means no borrow).
    always_comb begin
        w_alu = '0;
        unique case (r_op)
            2'b00:   w_alu = {1'b0, r_opnd_a} + {1'b0, r_opnd_b};
            2'b01:   w_alu = {1'b0, r_opnd_a} + {1'b0, ~r_opnd_b} + AluW'(1);
            2'b10:   w_alu = {1'b0, r_opnd_a & r_opnd_b};
            default: w_alu = {1'b0, r_opnd_a};
        endcase
    end

    // Datapath and registered bus outputs; each output is loaded one edge ahead of its state.
    always_ff @(posedge SC_RegBUSSEQ_CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
        if (SC_RegGENERAL_Reset_InHigh) begin
            r_src_a  <= '0;
            r_src_b  <= '0;
            r_dst    <= '0;
            r_op     <= '0;
            r_opnd_a <= '0;
            r_opnd_b <= '0;
            r_en_a   <= '0;
            r_en_b   <= '0;
            r_wr     <= '0;
            r_dout   <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_src_a <= bus.SC_RegBUSSEQ_SrcA;
                        r_src_b <= bus.SC_RegBUSSEQ_SrcB;
                        r_dst   <= bus.SC_RegBUSSEQ_Dst;
                        r_op    <= bus.SC_RegBUSSEQ_Op;
                        r_en_a  <= f_onehot(bus.SC_RegBUSSEQ_SrcA);
                        r_en_b  <= f_onehot(bus.SC_RegBUSSEQ_SrcB);
                    end
                end
                StRead: begin
                    r_opnd_a <= w_src_a_ok ? bus.SC_RegBUSSEQ_DataBUS_A : '0;
                    r_opnd_b <= w_src_b_ok ? bus.SC_RegBUSSEQ_DataBUS_B : '0;
                    r_en_a   <= '0;
                    r_en_b   <= '0;
                end
                StExec: begin
                    r_result <= w_alu[DATAWIDTH_BUS-1:0];
                    r_dout   <= w_alu[DATAWIDTH_BUS-1:0];
                    r_wr     <= f_onehot(r_dst);
                end
                StWrite: begin
                    r_wr   <= '0;
                    r_dout <= '0;
                    r_done <= 1'b1;
                end
                StDone:  r_done <= 1'b0;
                default: r_done <= 1'b0;
            endcase
        end
    end

`ifdef SC_REGBUSSEQ_STATUS_EN
    logic r_carry, r_zero;

    // Flags follow the result: updated only in EXEC.
    always_ff @(posedge SC_RegBUSSEQ_CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
        if (SC_RegGENERAL_Reset_InHigh) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if (r_state == StExec) begin
            r_carry <= w_alu[DATAWIDTH_BUS];
            r_zero  <= (w_alu[DATAWIDTH_BUS-1:0] == '0);
        end
    end

    assign bus.SC_RegBUSSEQ_Carry = r_carry;
    assign bus.SC_RegBUSSEQ_Zero  = r_zero;
`else
    logic w_unused_carry;
    assign w_unused_carry         = w_alu[DATAWIDTH_BUS];
    assign bus.SC_RegBUSSEQ_Carry = 1'b0;
    assign bus.SC_RegBUSSEQ_Zero  = 1'b0;
`endif

    assign bus.SC_RegBUSSEQ_ReqReady     = (r_state == StIdle);
    assign bus.SC_RegBUSSEQ_ENABLE_BUS_A = r_en_a;
    assign bus.SC_RegBUSSEQ_ENABLE_BUS_B = r_en_b;
    assign bus.SC_RegBUSSEQ_Write_InHigh = r_wr;
    assign bus.SC_RegBUSSEQ_DataBUS_Out  = r_dout;
    assign bus.SC_RegBUSSEQ_Done         = r_done;
    assign bus.SC_RegBUSSEQ_Result       = r_result;
endmodule

// File: tb/tb_sc_regbus_sequencer.sv
// Bench for sc_regbus_sequencer with a 6-register bank model (selects 6 and 7 are out of range).
module tb_sc_regbus_sequencer;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 6;
    localparam int unsigned SW = 3;

    typedef struct {
        logic [2:0]  srca, srcb, dst;
        logic [1:0]  op;
        logic [31:0] va, vb, res;
        logic        c, z;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        c, z;
        logic [2:0]  dst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] regs [NR];
    logic [31:0] bus_a, bus_b;
    exp_t        sb [$];
    vec_t        vecs [10];
    int          n_tests = 0;
    int          n_fail  = 0;

    sc_regbus_sequencer_if #(.DATAWIDTH_BUS(DW), .NUM_REGS(NR), .SEL_WIDTH(SW)) u_if ();

    sc_regbus_sequencer #(.DATAWIDTH_BUS(DW), .NUM_REGS(NR), .SEL_WIDTH(SW)) u_dut (
        .SC_RegBUSSEQ_CLOCK_50      (clk),
        .SC_RegGENERAL_Reset_InHigh (rst),
        .bus                        (u_if)
    );

    always #10 clk = ~clk;

    // Register bank read side: enabled registers drive the shared buses.
    always_comb begin
        bus_a = '0;
        bus_b = '0;
        for (int i = 0; i < NR; i++) begin
            if (u_if.SC_RegBUSSEQ_ENABLE_BUS_A[i]) bus_a = bus_a | regs[i];
            if (u_if.SC_RegBUSSEQ_ENABLE_BUS_B[i]) bus_b = bus_b | regs[i];
        end
    end
    assign u_if.SC_RegBUSSEQ_DataBUS_A = bus_a;
    assign u_if.SC_RegBUSSEQ_DataBUS_B = bus_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [NR-1:0] oh(input logic [2:0] s);
        logic [NR-1:0] one;
        one = 1;
        return (s < 3'd6) ? (one << s) : '0;
    endfunction

    function automatic logic exp_c(input logic c);
`ifdef SC_REGBUSSEQ_STATUS_EN
        return c;
`else
        return 1'b0 & c;
`endif
    endfunction

    // Scoreboard: every Done pulse retires the oldest accepted request.
    always @(negedge clk) begin
        if (u_if.SC_RegBUSSEQ_Done) begin
            if (sb.size() == 0) begin
                check("done_without_request", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", u_if.SC_RegBUSSEQ_Result, e.res);
                check("carry", {31'd0, u_if.SC_RegBUSSEQ_Carry}, {31'd0, e.c});
                check("zero", {31'd0, u_if.SC_RegBUSSEQ_Zero}, {31'd0, e.z});
                if (e.dst < 3'd6) check("writeback", regs[e.dst], e.res);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int guard;
        if (v.srca < 3'd6) regs[v.srca] = v.va;
        if (v.srcb < 3'd6) regs[v.srcb] = v.vb;
        guard = 0;
        while (!u_if.SC_RegBUSSEQ_ReqReady && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (!u_if.SC_RegBUSSEQ_ReqReady) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        u_if.SC_RegBUSSEQ_SrcA     = v.srca;
        u_if.SC_RegBUSSEQ_SrcB     = v.srcb;
        u_if.SC_RegBUSSEQ_Dst      = v.dst;
        u_if.SC_RegBUSSEQ_Op       = v.op;
        u_if.SC_RegBUSSEQ_ReqValid = 1'b1;
        sb.push_back('{res: v.res, c: exp_c(v.c), z: exp_c(v.z), dst: v.dst});
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                u_if.SC_RegBUSSEQ_ReqValid = 1'b0;
                // Fields must not matter after acceptance.
                u_if.SC_RegBUSSEQ_Dst = ~v.dst;
                check("en_a_read", 32'(u_if.SC_RegBUSSEQ_ENABLE_BUS_A), 32'(oh(v.srca)));
                check("en_b_read", 32'(u_if.SC_RegBUSSEQ_ENABLE_BUS_B), 32'(oh(v.srcb)));
                check("ready_busy", {31'd0, u_if.SC_RegBUSSEQ_ReqReady}, 32'd0);
            end else if (k == 2) begin
                check("en_a_exec", 32'(u_if.SC_RegBUSSEQ_ENABLE_BUS_A), 32'd0);
                check("dout_exec", u_if.SC_RegBUSSEQ_DataBUS_Out, 32'd0);
            end else if (k == 3) begin
                check("strobe_write", 32'(u_if.SC_RegBUSSEQ_Write_InHigh), 32'(oh(v.dst)));
                check("dout_write", u_if.SC_RegBUSSEQ_DataBUS_Out, v.res);
                for (int i = 0; i < NR; i++)
                    if (u_if.SC_RegBUSSEQ_Write_InHigh[i]) regs[i] = u_if.SC_RegBUSSEQ_DataBUS_Out;
            end else begin
                check("done_pulse", {31'd0, u_if.SC_RegBUSSEQ_Done}, 32'd1);
                check("strobe_done", 32'(u_if.SC_RegBUSSEQ_Write_InHigh), 32'd0);
                check("dout_done", u_if.SC_RegBUSSEQ_DataBUS_Out, 32'd0);
            end
        end
        @(negedge clk);
        check("done_one_cycle", {31'd0, u_if.SC_RegBUSSEQ_Done}, 32'd0);
    endtask

    initial begin
        int acc_cnt;
        int acc_at [$];
        //         srca  srcb  dst   op     va            vb            res           c     z
        vecs[0] = '{3'd1, 3'd2, 3'd3, 2'b00, 32'h5,        32'h3,        32'h8,        1'b0, 1'b0};
        vecs[1] = '{3'd4, 3'd4, 3'd5, 2'b01, 32'h1234,     32'h1234,     32'h0,        1'b1, 1'b1};
        vecs[2] = '{3'd0, 3'd1, 3'd0, 2'b00, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b1};
        vecs[3] = '{3'd2, 3'd5, 3'd1, 2'b01, 32'h3,        32'h5,        32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[4] = '{3'd1, 3'd2, 3'd2, 2'b10, 32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 1'b0, 1'b0};
        vecs[5] = '{3'd3, 3'd7, 3'd7, 2'b11, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        vecs[6] = '{3'd6, 3'd1, 3'd4, 2'b00, 32'h0,        32'h10,       32'h10,       1'b0, 1'b0};
        vecs[7] = '{3'd1, 3'd2, 3'd3, 2'b10, 32'hF0,       32'h0F,       32'h0,        1'b0, 1'b1};
        vecs[8] = '{3'd0, 3'd1, 3'd2, 2'b01, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[9] = '{3'd5, 3'd5, 3'd5, 2'b11, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1};

        for (int i = 0; i < NR; i++) regs[i] = 32'(i) * 32'h111;
        u_if.SC_RegBUSSEQ_ReqValid = 1'b0;
        u_if.SC_RegBUSSEQ_SrcA     = '0;
        u_if.SC_RegBUSSEQ_SrcB     = '0;
        u_if.SC_RegBUSSEQ_Dst      = '0;
        u_if.SC_RegBUSSEQ_Op       = '0;

        // Reset state.
        #5;
        check("rst_ready", {31'd0, u_if.SC_RegBUSSEQ_ReqReady}, 32'd1);
        check("rst_en_a", 32'(u_if.SC_RegBUSSEQ_ENABLE_BUS_A), 32'd0);
        check("rst_strobe", 32'(u_if.SC_RegBUSSEQ_Write_InHigh), 32'd0);
        check("rst_dout", u_if.SC_RegBUSSEQ_DataBUS_Out, 32'd0);
        check("rst_done", {31'd0, u_if.SC_RegBUSSEQ_Done}, 32'd0);
        check("rst_result", u_if.SC_RegBUSSEQ_Result, 32'd0);
        check("rst_flags", {30'd0, u_if.SC_RegBUSSEQ_Carry, u_if.SC_RegBUSSEQ_Zero}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Valid held high for 20 cycles: accepts every 5 cycles only.
        regs[1] = 32'h5;
        regs[2] = 32'h3;
        u_if.SC_RegBUSSEQ_SrcA     = 3'd1;
        u_if.SC_RegBUSSEQ_SrcB     = 3'd2;
        u_if.SC_RegBUSSEQ_Dst      = 3'd7;
        u_if.SC_RegBUSSEQ_Op       = 2'b00;
        u_if.SC_RegBUSSEQ_ReqValid = 1'b1;
        acc_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            if (u_if.SC_RegBUSSEQ_ReqReady) begin
                acc_cnt++;
                acc_at.push_back(i);
                sb.push_back('{res: 32'h8, c: 1'b0, z: 1'b0, dst: 3'd7});
            end
        end
        u_if.SC_RegBUSSEQ_ReqValid = 1'b0;
        check("held_valid_accepts", 32'(acc_cnt), 32'd4);
        for (int i = 1; i < acc_at.size(); i++)
            check("accept_spacing", 32'(acc_at[i] - acc_at[i-1]), 32'd5);
        @(negedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        // Reset asserted during WRITE kills the strobe at once.
        regs[1] = 32'h77;
        u_if.SC_RegBUSSEQ_SrcA     = 3'd1;
        u_if.SC_RegBUSSEQ_SrcB     = 3'd1;
        u_if.SC_RegBUSSEQ_Dst      = 3'd2;
        u_if.SC_RegBUSSEQ_Op       = 2'b00;
        u_if.SC_RegBUSSEQ_ReqValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u_if.SC_RegBUSSEQ_ReqValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_strobe", 32'(u_if.SC_RegBUSSEQ_Write_InHigh), 32'h4);
        rst = 1'b1;
        #1;
        check("rst_write_strobe", 32'(u_if.SC_RegBUSSEQ_Write_InHigh), 32'd0);
        check("rst_write_ready", {31'd0, u_if.SC_RegBUSSEQ_ReqReady}, 32'd1);
        check("rst_write_done", {31'd0, u_if.SC_RegBUSSEQ_Done}, 32'd0);
        check("rst_write_result", u_if.SC_RegBUSSEQ_Result, 32'd0);
        check("rst_write_dout", u_if.SC_RegBUSSEQ_DataBUS_Out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("no_done_after_reset", {31'd0, u_if.SC_RegBUSSEQ_Done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
